// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (loadable counter, timers, prescalers).
package counter_pkg;

    // Direction encoding on the `up` input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Limit behaviour selected by the SATURATE parameter
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Largest legal count for a given modulus, trimmed to the register width.
    function automatic int unsigned calc_max(input int unsigned modulus,
                                             input int unsigned width);
        int unsigned raw;
        raw = modulus - 1;
        if (width >= 32) begin
            return raw;
        end
        return raw & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/counter_limit_cmp.sv
// Combinational limit detection for a count register: flags the top and
// bottom of the range and picks the one that matters for the current direction.
module counter_limit_cmp
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  MAX_VALUE = '1
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    output logic             at_limit,
    output logic             is_max,
    output logic             is_zero
);

    // Range-end flags and the direction-selected limit
    always_comb begin
        is_max   = (value == MAX_VALUE);
        is_zero  = (value == '0);
        at_limit = (up == DIR_UP) ? is_max : is_zero;
    end

endmodule

// File: rtl/loadable_updown_counter.sv
// Synchronous up/down counter with parallel load, programmable modulus,
// wrap or saturate at the range ends, cascade carry and a sticky overflow flag.
module loadable_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 1 << WIDTH,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cin,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             cout,
    output logic             at_limit,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(calc_max(MODULUS, WIDTH));

    logic             is_max;
    logic             is_zero;
    logic             count_evt;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             overflow_next;

    counter_limit_cmp #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX)
    ) u_limit_cmp (
        .value    (value),
        .up       (up),
        .at_limit (at_limit),
        .is_max   (is_max),
        .is_zero  (is_zero)
    );

    // Count step: wrap or hold at the range ends, flag every hit of the limit
    always_comb begin
        count_evt     = en & cin;
        count_next    = value;
        overflow_next = overflow;
        if (count_evt) begin
            if (up == DIR_UP) begin
                if (is_max) begin
                    count_next = (SATURATE == MODE_SAT) ? MAX : '0;
                end else begin
                    count_next = value + 1'b1;
                end
            end else begin
                if (is_zero) begin
                    count_next = (SATURATE == MODE_SAT) ? '0 : MAX;
                end else begin
                    count_next = value - 1'b1;
                end
            end
            if (at_limit) begin
                overflow_next = 1'b1;
            end
        end
    end

    // Out-of-range loads clamp to the top of the count range
    always_comb begin
        load_clamped = (load_value > MAX) ? MAX : load_value;
    end

    // Carry-out for cascading: this stage is about to roll over (or would, if saturating)
    always_comb begin
        cout = en & cin & at_limit;
    end

    // State update with priority reset > clear > load > count/hold
    always_ff @(posedge clk) begin
        if (reset) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            value    <= load_clamped;
        end else begin
            value    <= count_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_loadable_updown_counter.sv
// Self-checking bench for loadable_updown_counter: wrap and saturate
// instances (WIDTH=4, MODULUS=10) plus a two-stage decimal cascade.
module tb_loadable_updown_counter;
    import counter_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int MX  = MOD - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the wrap and saturate instances
    logic         reset, en, cin, up, load, clear;
    logic [W-1:0] load_value;
    logic [W-1:0] w_value, s_value;
    logic         w_cout, s_cout, w_at_limit, s_at_limit, w_overflow, s_overflow;

    // Cascade stimulus
    logic         c_reset, c_en, c_up;
    logic [W-1:0] lo_value, hi_value;
    logic         lo_cout, hi_cout, lo_at_limit, hi_at_limit, lo_overflow, hi_overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mw_v, mw_o, ms_v, ms_o;
    int casc_n;

    loadable_updown_counter #(.WIDTH(W), .MODULUS(MOD), .SATURATE(MODE_WRAP)) dut_w (
        .clk(clk), .reset(reset), .en(en), .cin(cin), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .value(w_value), .cout(w_cout),
        .at_limit(w_at_limit), .overflow(w_overflow)
    );

    loadable_updown_counter #(.WIDTH(W), .MODULUS(MOD), .SATURATE(MODE_SAT)) dut_s (
        .clk(clk), .reset(reset), .en(en), .cin(cin), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .value(s_value), .cout(s_cout),
        .at_limit(s_at_limit), .overflow(s_overflow)
    );

    loadable_updown_counter #(.WIDTH(W), .MODULUS(MOD), .SATURATE(MODE_WRAP)) dut_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .cin(1'b1), .up(c_up), .load(1'b0),
        .load_value(4'd0), .clear(1'b0), .value(lo_value), .cout(lo_cout),
        .at_limit(lo_at_limit), .overflow(lo_overflow)
    );

    loadable_updown_counter #(.WIDTH(W), .MODULUS(MOD), .SATURATE(MODE_WRAP)) dut_hi (
        .clk(clk), .reset(c_reset), .en(c_en), .cin(lo_cout), .up(c_up), .load(1'b0),
        .load_value(4'd0), .clear(1'b0), .value(hi_value), .cout(hi_cout),
        .at_limit(hi_at_limit), .overflow(hi_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural rule set for one clock edge of a MODULUS=10 counter
    task automatic model_edge(input int sat, inout int v, inout int ov);
        if (reset) begin
            v = 0; ov = 0;
        end else if (clear) begin
            v = 0; ov = 0;
        end else if (load) begin
            v = (int'(load_value) > MX) ? MX : int'(load_value);
        end else if (en && cin) begin
            if (up) begin
                if (v == MX) begin ov = 1; v = sat ? MX : 0; end
                else v = v + 1;
            end else begin
                if (v == 0) begin ov = 1; v = sat ? 0 : MX; end
                else v = v - 1;
            end
        end
    endtask

    function automatic int exp_limit(input int v);
        return up ? int'(v == MX) : int'(v == 0);
    endfunction

    // One cycle of the wrap/saturate pair: combinational checks, edge, registered checks
    task automatic step(input string tag);
        #1;
        check({tag, " w.at_limit"}, w_at_limit, exp_limit(mw_v));
        check({tag, " w.cout"}, w_cout, int'(en && cin) & exp_limit(mw_v));
        check({tag, " s.at_limit"}, s_at_limit, exp_limit(ms_v));
        check({tag, " s.cout"}, s_cout, int'(en && cin) & exp_limit(ms_v));
        @(posedge clk);
        model_edge(0, mw_v, mw_o);
        model_edge(1, ms_v, ms_o);
        #1;
        check({tag, " w.value"}, w_value, mw_v);
        check({tag, " w.overflow"}, w_overflow, mw_o);
        check({tag, " s.value"}, s_value, ms_v);
        check({tag, " s.overflow"}, s_overflow, ms_o);
    endtask

    // One cycle of the cascade, modelled as a single 0..99 decimal count
    task automatic cstep(input string tag);
        #1;
        check({tag, " lo.cout"}, lo_cout, int'(c_en) & (c_up ? int'(casc_n % 10 == 9) : int'(casc_n % 10 == 0)));
        check({tag, " hi.cout"}, hi_cout, int'(c_en) & (c_up ? int'(casc_n == 99) : int'(casc_n == 0)));
        @(posedge clk);
        if (c_reset) casc_n = 0;
        else if (c_en) casc_n = c_up ? (casc_n + 1) % 100 : (casc_n + 99) % 100;
        #1;
        check({tag, " lo.value"}, lo_value, casc_n % 10);
        check({tag, " hi.value"}, hi_value, casc_n / 10);
    endtask

    initial begin
        mw_v = 0; mw_o = 0; ms_v = 0; ms_o = 0; casc_n = 0;
        reset = 1; en = 0; cin = 1; up = 1; load = 0; clear = 0; load_value = '0;
        c_reset = 1; c_en = 0; c_up = 1;
        @(posedge clk);

        // Reset state
        step("reset");
        check("reset w.value const", w_value, 0);
        check("reset w.overflow const", w_overflow, 0);

        // Count up with wrap 0..9,0,1
        reset = 0; en = 1; cin = 1; up = 1;
        for (int i = 0; i < 12; i++) step("up_wrap");
        check("up_wrap w.value const", w_value, 2);
        check("up_wrap w.overflow const", w_overflow, 1);
        check("up_wrap s.value const", s_value, 9);

        // Down wrap from 0
        clear = 1; step("clear");
        clear = 0; load = 1; load_value = 4'd0; step("load0");
        load = 0; up = 0;
        for (int i = 0; i < 3; i++) step("down_wrap");
        check("down_wrap w.value const", w_value, 7);
        check("down_wrap w.overflow const", w_overflow, 1);

        // Saturate at the top, then step back down
        clear = 1; step("clear2");
        clear = 0; load = 1; load_value = 4'd8; step("load8");
        load = 0; up = 1;
        for (int i = 0; i < 4; i++) step("sat_up");
        check("sat_up s.value const", s_value, 9);
        check("sat_up s.overflow const", s_overflow, 1);
        up = 0; step("sat_down");
        check("sat_down s.value const", s_value, 8);

        // Load clamp and priority
        load = 1; en = 1; load_value = 4'd13; step("load_clamp");
        check("load_clamp w.value const", w_value, 9);
        clear = 1; step("clear_over_load");
        check("clear_over_load w.value const", w_value, 0);
        check("clear_over_load w.overflow const", w_overflow, 0);
        load_value = 4'd5; step("load5_clear");
        clear = 0; step("load5");
        reset = 1; step("reset_over_load");
        check("reset_over_load w.value const", w_value, 0);

        // Hold with en=0, then with cin=0
        reset = 0; load_value = 4'd6; step("load6");
        load = 0; en = 0; up = 1;
        for (int i = 0; i < 5; i++) step("hold_en");
        en = 1; cin = 0;
        for (int i = 0; i < 5; i++) step("hold_cin");
        check("hold w.value const", w_value, 6);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(31) == 0);
            clear      = ($urandom_range(15) == 0);
            load       = ($urandom_range(7) == 0);
            en         = ($urandom_range(3) != 0);
            cin        = ($urandom_range(3) != 0);
            up         = $urandom_range(1) == 1;
            load_value = W'($urandom_range(15));
            step("random");
        end

        // Cascade: park the single-stage pair in reset
        reset = 1; load = 0; clear = 0; en = 0;
        cstep("casc_reset");
        c_reset = 0; c_en = 1; c_up = 1;
        for (int i = 0; i < 25; i++) cstep("casc_up");
        check("casc_up hi const", hi_value, 2);
        check("casc_up lo const", lo_value, 5);
        for (int i = 0; i < 250; i++) begin
            c_en = ($urandom_range(3) != 0);
            c_up = ($urandom_range(3) != 0);
            cstep("casc_random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loadable_updown_counter.md
Name: loadable_updown_counter

Overview:
- Parametrised successor to the single-direction ripple counter: fully synchronous binary counter, one clock domain.
- Adds parallel load, up/down direction, programmable modulus, wrap or saturate mode, enable, carry-in/carry-out for cascading, and a sticky overflow flag.
- Used as the general counter primitive for the counter-with-load project and later timer and prescaler blocks.

Parameters:
- WIDTH, 8, bit width of the count register and load value.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- en  in  1  count enable.
- cin  in  1  carry-in for cascading; tie to 1 when standalone.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value to load.
- clear  in  1  synchronous clear of count and overflow.
- value  out  WIDTH  current count, registered.
- cout  out  1  carry-out, combinational.
- at_limit  out  1  value equals the limit for the current direction, combinational.
- overflow  out  1  sticky wrap/saturation-hit flag, registered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: value = 0, overflow = 0.
- Limits: MAX = MODULUS-1 (constant, width WIDTH). LIMIT = MAX when up = 1; LIMIT = 0 when up = 0.
- Priority per edge: reset > clear > load > count > hold.
- clear: value <= 0, overflow <= 0.
- load: value <= min(load_value, MAX), so an out-of-range load clamps to MAX. overflow is unchanged. Load takes effect regardless of en/cin.
- Count event: occurs when en & cin, with no reset, clear or load.
  - up, value < MAX: value+1.
  - up, value = MAX: 0 (SATURATE = 0) or MAX (SATURATE = 1).
  - down, value > 0: value-1.
  - down, value = 0: MAX (SATURATE = 0) or 0 (SATURATE = 1).
- overflow: set to 1 on any count event that occurs while value = LIMIT, in either mode. Stays set until clear or reset.
- at_limit = (value == LIMIT). Follows `up` combinationally.
- cout = en & cin & at_limit.
  - Cascade: the next stage's cin = this stage's cout, with shared clk, en and up. The upper stage then steps exactly on the lower stage's wrap.
  - cout is asserted even when SATURATE = 1.
- Latency: one cycle from load/clear/count to value; zero from inputs to cout/at_limit.
- Direction change mid-count takes effect on the same edge. No glitch state is allowed.
- A reset asserted mid-count overrides everything on that edge.
- Arithmetic: modulo 2**WIDTH internally. The MODULUS compare prevents illegal values, so value never exceeds MAX.

Decomposition:
- Shared package counter_pkg holds:
  - constants DIR_DOWN = 0 and DIR_UP = 1;
  - MODE_WRAP = 0 and MODE_SAT = 1;
  - a function computing MAX from MODULUS and WIDTH.
- One sub-module is natural: counter_limit_cmp (combinational).
  - Inputs: value, up. Outputs: at_limit, is_max, is_zero.
  - Shared with the future timer block.
- The next-state mux and overflow register stay in the top module.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset/count/wrap: reset, then en=cin=up=1 for 12 cycles -> value 0,1..9,0,1; cout high only in the cycle value=9; overflow set after the 9->0 edge.
- Down wrap: load 0, up=0, en=1 for 3 cycles -> value 9,8,7; cout high while value=0; overflow=1.
- Saturate (SATURATE=1): load 8, up=1, en=1 for 4 cycles -> 9,9,9,9; overflow=1; then up=0 for one cycle -> 8.
- Load clamp and priority: load_value=13 with load=1, en=1 -> value=9. The same cycle with clear=1 -> value=0, overflow=0. reset=1 together with load -> value=0.
- Cascade: two instances (WIDTH=4, MODULUS=10), low cout -> high cin, en=up=1 for 25 cycles -> {high,low} = 2,5; high stage increments only on the low 9->0 edges.
- Hold: en=0 or cin=0 for 5 cycles at value=6 -> value stays 6, cout=0, overflow unchanged.
